// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types and hazard control encodings
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } hazard_ctrl_t;

    localparam hazard_ctrl_t CTRL_RUN      = hazard_ctrl_t'(8'b11111_000);
    localparam hazard_ctrl_t CTRL_FREEZE   = hazard_ctrl_t'(8'b00000_000);
    localparam hazard_ctrl_t CTRL_BRANCH   = hazard_ctrl_t'(8'b11111_111);
    localparam hazard_ctrl_t CTRL_LOAD_USE = hazard_ctrl_t'(8'b00111_010);
    localparam hazard_ctrl_t CTRL_IMISS    = hazard_ctrl_t'(8'b01111_100);

    // r0 is hardwired zero, so a load targeting it can never create a dependency.
    function automatic logic load_use_hit(input logic     mem_read,
                                          input regbits_t wsel,
                                          input regbits_t rs,
                                          input regbits_t rt);
        return mem_read && (wsel != '0) && ((wsel == rs) || (wsel == rt));
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline hazard control bundle between datapath and hazard unit
interface hazard_unit_if;
    import cpu_types_pkg::*;

    regbits_t IDrs;
    regbits_t IDrt;
    regbits_t EXwsel;
    logic     EXMemRead;
    logic     MEMbranch;
    logic     MEMdREN;
    logic     MEMdWEN;
    logic     dhit;
    logic     ihit;
    logic     WBhalt;

    logic     PCEn;
    logic     IFIDen;
    logic     IDEXen;
    logic     EXMEMen;
    logic     MEMWBen;
    logic     IFIDflush;
    logic     IDEXflush;
    logic     EXMEMflush;
    word_t    stall_cnt;
    word_t    flush_cnt;

    modport hu (
        input  IDrs, IDrt, EXwsel, EXMemRead, MEMbranch, MEMdREN, MEMdWEN, dhit, ihit, WBhalt,
        output PCEn, IFIDen, IDEXen, EXMEMen, MEMWBen, IFIDflush, IDEXflush, EXMEMflush,
        output stall_cnt, flush_cnt
    );

    modport hutb (
        output IDrs, IDrt, EXwsel, EXMemRead, MEMbranch, MEMdREN, MEMdWEN, dhit, ihit, WBhalt,
        input  PCEn, IFIDen, IDEXen, EXMEMen, MEMWBen, IFIDflush, IDEXflush, EXMEMflush,
        input  stall_cnt, flush_cnt
    );

endinterface

// File: rtl/event_counter.sv
// rtl/event_counter.sv - 32-bit wrapping event counter with enable and async clear
import cpu_types_pkg::*;

module event_counter (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  en_i,
    output word_t count_o
);

    word_t count_q;
    word_t count_d;

    // Natural modulo-2^32 overflow gives the 0xFFFFFFFF -> 0 wrap.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + word_t'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - five-stage pipeline stall/flush controller with performance counters
import cpu_types_pkg::*;

module hazard_unit (
    input  logic       CLK,
    input  logic       nRST,
    hazard_unit_if.hu  hif
);

    hazard_state_t state_q;
    hazard_state_t state_d;
    hazard_ctrl_t  ctrl;
    hazard_ctrl_t  ctrl_out;
    logic          dmem_wait;
    logic          load_use;
    logic          flush_ev;
    logic          stall_ev;
    word_t         stall_cnt;
    word_t         flush_cnt;

    assign dmem_wait = (hif.MEMdREN || hif.MEMdWEN) && !hif.dhit;
    assign load_use  = load_use_hit(hif.EXMemRead, hif.EXwsel, hif.IDrs, hif.IDrt);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A DWAIT cycle that sees dhit is decoded exactly like RUN with the miss gone.
    always_comb begin
        ctrl     = CTRL_RUN;
        state_d  = state_q;
        flush_ev = 1'b0;
        if (state_q == HALTED) begin
            ctrl = CTRL_FREEZE;
        end else if ((state_q == DWAIT) && !hif.dhit) begin
            ctrl = CTRL_FREEZE;
        end else if (hif.WBhalt) begin
            ctrl    = CTRL_FREEZE;
            state_d = HALTED;
        end else if ((state_q == RUN) && dmem_wait) begin
            ctrl    = CTRL_FREEZE;
            state_d = DWAIT;
        end else begin
            state_d = RUN;
            if (hif.MEMbranch) begin
                ctrl     = CTRL_BRANCH;
                flush_ev = 1'b1;
            end else if (load_use) begin
                ctrl = CTRL_LOAD_USE;
            end else if (!hif.ihit) begin
                ctrl = CTRL_IMISS;
            end
        end
    end

    assign stall_ev = !ctrl.pc_en && (state_q != HALTED) && (state_d != HALTED);
    assign ctrl_out = nRST ? ctrl : CTRL_FREEZE;

    event_counter u_stall_cnt (
        .CLK     (CLK),
        .nRST    (nRST),
        .en_i    (stall_ev),
        .count_o (stall_cnt)
    );

    event_counter u_flush_cnt (
        .CLK     (CLK),
        .nRST    (nRST),
        .en_i    (flush_ev),
        .count_o (flush_cnt)
    );

    assign hif.PCEn       = ctrl_out.pc_en;
    assign hif.IFIDen     = ctrl_out.ifid_en;
    assign hif.IDEXen     = ctrl_out.idex_en;
    assign hif.EXMEMen    = ctrl_out.exmem_en;
    assign hif.MEMWBen    = ctrl_out.memwb_en;
    assign hif.IFIDflush  = ctrl_out.ifid_flush;
    assign hif.IDEXflush  = ctrl_out.idex_flush;
    assign hif.EXMEMflush = ctrl_out.exmem_flush;
    assign hif.stall_cnt  = stall_cnt;
    assign hif.flush_cnt  = flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard testbench for hazard_unit
module tb_hazard_unit;

    localparam logic [7:0] C_RUN = 8'b11111_000;
    localparam logic [7:0] C_FRZ = 8'b00000_000;
    localparam logic [7:0] C_BR  = 8'b11111_111;
    localparam logic [7:0] C_LU  = 8'b00111_010;
    localparam logic [7:0] C_IM  = 8'b01111_100;

    typedef struct {
        string       name;
        logic [4:0]  rs, rt, ws;
        logic        exmr, br, dren, dwen, halt, dhit, ihit;
        logic [7:0]  ctrl;
        logic [31:0] stall, flush;
    } step_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   passed = 0;
    step_t exp_q[$];

    hazard_unit_if hif ();

    hazard_unit dut (
        .CLK  (CLK),
        .nRST (nRST),
        .hif  (hif)
    );

    always #5 CLK = ~CLK;

    function automatic step_t mk(string n, logic [4:0] rs, logic [4:0] rt, logic [4:0] ws,
                                 logic exmr, logic br, logic dren, logic dwen, logic halt,
                                 logic dhit, logic ihit, logic [7:0] ctrl,
                                 logic [31:0] stall, logic [31:0] flush);
        step_t s;
        s.name = n; s.rs = rs; s.rt = rt; s.ws = ws; s.exmr = exmr; s.br = br;
        s.dren = dren; s.dwen = dwen; s.halt = halt; s.dhit = dhit; s.ihit = ihit;
        s.ctrl = ctrl; s.stall = stall; s.flush = flush;
        return s;
    endfunction

    function automatic logic [7:0] ctrl_obs();
        return {hif.PCEn, hif.IFIDen, hif.IDEXen, hif.EXMEMen, hif.MEMWBen,
                hif.IFIDflush, hif.IDEXflush, hif.EXMEMflush};
    endfunction

    task automatic drive(input step_t s);
        hif.IDrs = s.rs; hif.IDrt = s.rt; hif.EXwsel = s.ws; hif.EXMemRead = s.exmr;
        hif.MEMbranch = s.br; hif.MEMdREN = s.dren; hif.MEMdWEN = s.dwen;
        hif.WBhalt = s.halt; hif.dhit = s.dhit; hif.ihit = s.ihit;
    endtask

    task automatic drive_idle();
        drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0, 0));
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        drive_idle();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        drive(mk("rst", 0, 5, 5, 1, 1, 1, 0, 0, 0, 0, C_FRZ, 0, 0));
        #1;
        checks++;
        if (ctrl_obs() !== C_FRZ) $display("FAIL reset_ctrl got %b want %b", ctrl_obs(), C_FRZ);
        else passed++;
        checks++;
        if ({hif.stall_cnt, hif.flush_cnt} !== 64'd0)
            $display("FAIL reset_cnt got %h/%h want 0/0", hif.stall_cnt, hif.flush_cnt);
        else passed++;
    endtask

    task automatic test_load_use();
        step_t st[$];
        step_t e;
        do_reset();
        st.push_back(mk("lu_rt",    0, 5, 5, 1, 0, 0, 0, 0, 1, 1, C_LU,  1, 0));
        st.push_back(mk("lu_rs",    5, 0, 5, 1, 0, 0, 0, 0, 1, 1, C_LU,  2, 0));
        st.push_back(mk("lu_clear", 0, 5, 5, 0, 0, 0, 0, 0, 1, 1, C_RUN, 2, 0));
        st.push_back(mk("ld_nodep", 3, 4, 5, 1, 0, 0, 0, 0, 1, 1, C_RUN, 2, 0));
        st.push_back(mk("r0_rs",    0, 0, 0, 1, 0, 0, 0, 0, 1, 1, C_RUN, 2, 0));
        st.push_back(mk("r0_rt",    7, 0, 0, 1, 0, 0, 0, 0, 1, 1, C_RUN, 2, 0));
        foreach (st[i]) begin
            drive(st[i]); exp_q.push_back(st[i]);
            #2; e = exp_q.pop_front();
            checks++;
            if (ctrl_obs() !== e.ctrl) $display("FAIL %s ctrl got %b want %b", e.name, ctrl_obs(), e.ctrl);
            else passed++;
            @(posedge CLK); #1;
            checks++;
            if (hif.stall_cnt !== e.stall || hif.flush_cnt !== e.flush)
                $display("FAIL %s cnt got %0d/%0d want %0d/%0d", e.name, hif.stall_cnt, hif.flush_cnt, e.stall, e.flush);
            else passed++;
            @(negedge CLK);
        end
    endtask

    task automatic test_dmem_wait();
        step_t st[$];
        step_t e;
        do_reset();
        st.push_back(mk("dw1",    0, 0, 0, 0, 0, 1, 0, 0, 0, 1, C_FRZ, 1, 0));
        st.push_back(mk("dw2",    0, 0, 0, 0, 0, 1, 0, 0, 0, 1, C_FRZ, 2, 0));
        st.push_back(mk("dw3",    0, 0, 0, 0, 0, 1, 0, 0, 0, 1, C_FRZ, 3, 0));
        st.push_back(mk("dw_hit", 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, C_RUN, 3, 0));
        st.push_back(mk("in_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 3, 0));
        st.push_back(mk("dw_wr",  0, 0, 0, 0, 0, 0, 1, 0, 0, 1, C_FRZ, 4, 0));
        st.push_back(mk("wr_hit", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, C_IM,  5, 0));
        foreach (st[i]) begin
            drive(st[i]); exp_q.push_back(st[i]);
            #2; e = exp_q.pop_front();
            checks++;
            if (ctrl_obs() !== e.ctrl) $display("FAIL %s ctrl got %b want %b", e.name, ctrl_obs(), e.ctrl);
            else passed++;
            @(posedge CLK); #1;
            checks++;
            if (hif.stall_cnt !== e.stall || hif.flush_cnt !== e.flush)
                $display("FAIL %s cnt got %0d/%0d want %0d/%0d", e.name, hif.stall_cnt, hif.flush_cnt, e.stall, e.flush);
            else passed++;
            @(negedge CLK);
        end
    endtask

    task automatic test_branch();
        step_t st[$];
        step_t e;
        do_reset();
        st.push_back(mk("br_lu",   0, 5, 5, 1, 1, 0, 0, 0, 1, 1, C_BR,  0, 1));
        st.push_back(mk("br_imiss",0, 0, 0, 0, 1, 0, 0, 0, 1, 0, C_BR,  0, 2));
        st.push_back(mk("imiss",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_IM,  1, 2));
        st.push_back(mk("br_dw1",  0, 0, 0, 0, 1, 1, 0, 0, 0, 1, C_FRZ, 2, 2));
        st.push_back(mk("br_dw2",  0, 0, 0, 0, 1, 1, 0, 0, 0, 1, C_FRZ, 3, 2));
        st.push_back(mk("br_dhit", 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, C_BR,  3, 3));
        st.push_back(mk("idle",    0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 3, 3));
        foreach (st[i]) begin
            drive(st[i]); exp_q.push_back(st[i]);
            #2; e = exp_q.pop_front();
            checks++;
            if (ctrl_obs() !== e.ctrl) $display("FAIL %s ctrl got %b want %b", e.name, ctrl_obs(), e.ctrl);
            else passed++;
            @(posedge CLK); #1;
            checks++;
            if (hif.stall_cnt !== e.stall || hif.flush_cnt !== e.flush)
                $display("FAIL %s cnt got %0d/%0d want %0d/%0d", e.name, hif.stall_cnt, hif.flush_cnt, e.stall, e.flush);
            else passed++;
            @(negedge CLK);
        end
    endtask

    task automatic test_halt();
        step_t st[$];
        step_t e;
        do_reset();
        st.push_back(mk("pre_im", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_IM,  1, 0));
        st.push_back(mk("halt",   0, 0, 0, 0, 0, 1, 0, 1, 0, 1, C_FRZ, 1, 0));
        st.push_back(mk("h_im",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1, 0));
        st.push_back(mk("h_br",   0, 0, 0, 0, 1, 1, 0, 0, 0, 1, C_FRZ, 1, 0));
        st.push_back(mk("h_lu",   0, 5, 5, 1, 0, 0, 0, 0, 1, 1, C_FRZ, 1, 0));
        st.push_back(mk("h_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_FRZ, 1, 0));
        foreach (st[i]) begin
            drive(st[i]); exp_q.push_back(st[i]);
            #2; e = exp_q.pop_front();
            checks++;
            if (ctrl_obs() !== e.ctrl) $display("FAIL %s ctrl got %b want %b", e.name, ctrl_obs(), e.ctrl);
            else passed++;
            @(posedge CLK); #1;
            checks++;
            if (hif.stall_cnt !== e.stall || hif.flush_cnt !== e.flush)
                $display("FAIL %s cnt got %0d/%0d want %0d/%0d", e.name, hif.stall_cnt, hif.flush_cnt, e.stall, e.flush);
            else passed++;
            @(negedge CLK);
        end
        nRST = 1'b0;
        #1;
        checks++;
        if (hif.stall_cnt !== 32'd0 || hif.flush_cnt !== 32'd0)
            $display("FAIL halt_async_clr got %0d/%0d want 0/0", hif.stall_cnt, hif.flush_cnt);
        else passed++;
        @(negedge CLK);
        nRST = 1'b1;
        e = mk("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0, 0);
        drive(e); exp_q.push_back(e);
        #2; e = exp_q.pop_front();
        checks++;
        if (ctrl_obs() !== e.ctrl) $display("FAIL %s ctrl got %b want %b", e.name, ctrl_obs(), e.ctrl);
        else passed++;
        @(posedge CLK); #1;
        @(negedge CLK);
    endtask

    task automatic test_reset_dwait();
        step_t e;
        do_reset();
        e = mk("enter_dw", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, C_FRZ, 1, 0);
        drive(e); exp_q.push_back(e);
        @(posedge CLK); #1;
        do_reset();
        drive(mk("rel_dw", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0, 0));
        exp_q.push_back(mk("rel_dw", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0, 0));
        void'(exp_q.pop_front());
        #2; e = exp_q.pop_front();
        checks++;
        if (ctrl_obs() !== e.ctrl || hif.stall_cnt !== e.stall)
            $display("FAIL %s got %b/%0d want %b/%0d", e.name, ctrl_obs(), hif.stall_cnt, e.ctrl, e.stall);
        else passed++;
        @(negedge CLK);
    endtask

    task automatic test_wrap();
        step_t st[$];
        step_t e;
        do_reset();
        force dut.u_stall_cnt.count_q = 32'hFFFF_FFFF;
        force dut.u_flush_cnt.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_stall_cnt.count_q;
        release dut.u_flush_cnt.count_q;
        #1;
        checks++;
        if (hif.stall_cnt !== 32'hFFFF_FFFF || hif.flush_cnt !== 32'hFFFF_FFFF)
            $display("FAIL wrap_preload got %h/%h want ffffffff/ffffffff", hif.stall_cnt, hif.flush_cnt);
        else passed++;
        st.push_back(mk("wrap_st", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_IM, 32'd0, 32'hFFFF_FFFF));
        st.push_back(mk("wrap_fl", 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, C_BR, 32'd0, 32'd0));
        st.push_back(mk("post_wr", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_IM, 32'd1, 32'd0));
        foreach (st[i]) begin
            drive(st[i]); exp_q.push_back(st[i]);
            #2; e = exp_q.pop_front();
            checks++;
            if (ctrl_obs() !== e.ctrl) $display("FAIL %s ctrl got %b want %b", e.name, ctrl_obs(), e.ctrl);
            else passed++;
            @(posedge CLK); #1;
            checks++;
            if (hif.stall_cnt !== e.stall || hif.flush_cnt !== e.flush)
                $display("FAIL %s cnt got %h/%h want %h/%h", e.name, hif.stall_cnt, hif.flush_cnt, e.stall, e.flush);
            else passed++;
            @(negedge CLK);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_dmem_wait();
        test_branch();
        test_halt();
        test_reset_dwait();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
